// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the memory stage: services word/byte
// loads and stores with a fixed latency, stalling the pipeline until done.
module dmem_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_cmd,
  input  logic        write_cmd,
  input  logic        byte_access,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        done,
  output logic        stall,
  output logic        error
);

  localparam int unsigned DEPTH = 1 << (ADDR_BITS - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

  logic [1:0]           r_state;
  logic [3:0]           r_cnt;
  logic                 r_is_wr;
  logic                 r_byte;
  logic [ADDR_BITS-1:0] r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_read_data;
  logic [31:0]          r_mem [DEPTH];

  logic                  w_any;
  logic                  w_valid;
  logic                  w_commit;
  logic [ADDR_BITS-3:0]  w_idx;
  logic [4:0]            w_lane_bit;
  logic [31:0]           w_word;
  logic [31:0]           w_merged;
  logic [31:0]           w_load;
  logic                  w_unused_addr;

  assign w_any    = read_cmd | write_cmd;
  assign w_valid  = (read_cmd ^ write_cmd) && (byte_access || (address[1:0] == 2'b00));
  assign w_commit = (r_state == S_BUSY) && (r_cnt == '0);

  assign w_idx      = r_addr[ADDR_BITS-1:2];
  assign w_lane_bit = {r_addr[1:0], 3'b000};
  assign w_word     = r_mem[w_idx];

  // Upper address bits are deliberately not decoded: accesses wrap.
  assign w_unused_addr = ^address[31:ADDR_BITS];

  always_comb begin
    w_merged = r_wdata;
    if (r_byte) begin
      w_merged = w_word;
      w_merged[w_lane_bit +: 8] = r_wdata[7:0];
    end
  end

  always_comb begin
    w_load = w_word;
    if (r_byte) begin
      w_load = {24'h0, w_word[w_lane_bit +: 8]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_wr     <= 1'b0;
      r_byte      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            if (w_valid) begin
              r_state <= S_BUSY;
              r_cnt   <= CNT_LOAD;
              r_is_wr <= write_cmd;
              r_byte  <= byte_access;
              r_addr  <= address[ADDR_BITS-1:0];
              r_wdata <= write_data;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_BUSY: begin
          if (w_commit) begin
            r_state <= S_DONE;
            if (!r_is_wr) begin
              r_read_data <= w_load;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset on the commit edge suppresses the write, so an aborted store never lands.
  always_ff @(posedge clock) begin
    if (!reset && w_commit && r_is_wr) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign read_data = r_read_data;
  assign stall     = ((r_state == S_IDLE) && w_any) || (r_state == S_BUSY);
  assign done      = (r_state == S_DONE);
  assign error     = (r_state == S_ERR);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder; two instances (LATENCY 5 and 2)
// share the request bus, with per-instance command enables.
module tb_dmem_responder;

  localparam int LAT0 = 5;
  localparam int LAT1 = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  rd;
  logic [1:0]  wr;
  logic        byte_access;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [1:0][31:0] rdata;
  logic [1:0]  done_v;
  logic [1:0]  stall_v;
  logic [1:0]  error_v;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [2][256];
  logic [31:0] rd_exp [2];
  logic [31:0] sb [2][$];

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_BITS(10), .LATENCY(LAT0)) u_dut5 (
    .clock(clock), .reset(reset), .read_cmd(rd[0]), .write_cmd(wr[0]),
    .byte_access(byte_access), .address(address), .write_data(write_data),
    .read_data(rdata[0]), .done(done_v[0]), .stall(stall_v[0]), .error(error_v[0])
  );

  dmem_responder #(.ADDR_BITS(10), .LATENCY(LAT1)) u_dut2 (
    .clock(clock), .reset(reset), .read_cmd(rd[1]), .write_cmd(wr[1]),
    .byte_access(byte_access), .address(address), .write_data(write_data),
    .read_data(rdata[1]), .done(done_v[1]), .stall(stall_v[1]), .error(error_v[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string tag, input int d, input int c,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cycle %0d: got %h expected %h", tag, d, c, obs, exp);
    end
  endtask

  task automatic drive_idle();
    rd = '0; wr = '0; byte_access = 1'b0; address = '0; write_data = '0;
  endtask

  task automatic garbage(input logic [1:0] en);
    rd = 2'($urandom) & en;
    wr = 2'($urandom) & en;
    byte_access = 1'($urandom);
    address = $urandom;
    write_data = $urandom;
  endtask

  function automatic logic [31:0] model_load(input int d, input logic bt, input logic [31:0] a);
    logic [31:0] w;
    logic [1:0] ln;
    w = mem_m[d][a[9:2]];
    ln = a[1:0];
    if (bt) return {24'h0, w[int'(ln)*8 +: 8]};
    return w;
  endfunction

  task automatic model_store(input int d, input logic bt, input logic [31:0] a, input logic [31:0] wd);
    logic [1:0] ln;
    ln = a[1:0];
    if (bt) mem_m[d][a[9:2]][int'(ln)*8 +: 8] = wd[7:0];
    else    mem_m[d][a[9:2]] = wd;
  endtask

  task automatic pop_exp(input int d, input int c);
    if (sb[d].size() == 0) begin
      errors++;
      $error("FAIL sb_empty dut%0d cycle %0d: got 0 entries expected 1", d, c);
    end else begin
      rd_exp[d] = sb[d].pop_front();
    end
  endtask

  // Shared request to both instances; rst_cyc < 0 means no reset.
  task automatic request(input logic r, input logic w, input logic bt,
                         input logic [31:0] a, input logic [31:0] wd, input int rst_cyc);
    logic err;
    logic e_st, e_dn, e_er;
    err = (r && w) || (!bt && (a[1:0] != 2'b00));
    rd = {r, r}; wr = {w, w}; byte_access = bt; address = a; write_data = wd;
    for (int d = 0; d < 2; d++) begin
      if (r && !err) sb[d].push_back(model_load(d, bt, a));
      if (w && !err && (rst_cyc < 0 || lat(d) - 1 < rst_cyc)) model_store(d, bt, a, wd);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        if (rst_cyc >= 0 && c > rst_cyc) begin
          e_st = 1'b0; e_dn = 1'b0; e_er = 1'b0;
          if (c == rst_cyc + 1) rd_exp[d] = '0;
        end else if (err) begin
          e_st = (c == 0); e_dn = 1'b0; e_er = (c == 1);
        end else begin
          e_st = (c < lat(d)); e_dn = (c == lat(d)); e_er = 1'b0;
          if (e_dn && r) pop_exp(d, c);
        end
        chk("stall", d, c, 32'(stall_v[d]), 32'(e_st));
        chk("done", d, c, 32'(done_v[d]), 32'(e_dn));
        chk("error", d, c, 32'(error_v[d]), 32'(e_er));
        chk("read_data", d, c, rdata[d], rd_exp[d]);
      end
      @(posedge clock); #1;
      if (c == 0) garbage(2'b11);
      else drive_idle();
      reset = (rst_cyc >= 0 && c + 1 == rst_cyc);
    end
    reset = 1'b0;
  endtask

  // Two loads on one instance, the second presented the cycle after done.
  task automatic b2b(input int d);
    int L;
    int o;
    logic [1:0] en;
    logic e_st, e_dn;
    L = lat(d);
    o = 1 - d;
    en = (d == 0) ? 2'b01 : 2'b10;
    drive_idle();
    rd = en; address = 32'h010;
    sb[d].push_back(model_load(d, 1'b0, 32'h010));
    for (int c = 0; c < 2 * L + 3; c++) begin
      @(negedge clock);
      e_st = (c < L) || (c > L && c <= 2 * L);
      e_dn = (c == L) || (c == 2 * L + 1);
      if (e_dn) pop_exp(d, c);
      chk("b2b_stall", d, c, 32'(stall_v[d]), 32'(e_st));
      chk("b2b_done", d, c, 32'(done_v[d]), 32'(e_dn));
      chk("b2b_read_data", d, c, rdata[d], rd_exp[d]);
      chk("b2b_other_stall", o, c, 32'(stall_v[o]), 32'h0);
      @(posedge clock); #1;
      if (c + 1 == L + 1) begin
        drive_idle();
        rd = en; address = 32'h014;
        sb[d].push_back(model_load(d, 1'b0, 32'h014));
      end else if ((c + 1 >= 1 && c + 1 <= L - 1) || (c + 1 >= L + 2 && c + 1 <= 2 * L)) begin
        garbage(en);
      end else begin
        drive_idle();
      end
    end
    drive_idle();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_exp[d] = '0;
      for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
    end
    reset = 1'b1;
    drive_idle();
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall", d, 0, 32'(stall_v[d]), 32'h0);
      chk("rst_done", d, 0, 32'(done_v[d]), 32'h0);
      chk("rst_error", d, 0, 32'(error_v[d]), 32'h0);
      chk("rst_read_data", d, 0, rdata[d], 32'h0);
    end
    @(posedge clock); #1;
    reset = 1'b0;

    request(1'b0, 1'b1, 1'b0, 32'h010, 32'hDEADBEEF, -1);
    request(1'b1, 1'b0, 1'b0, 32'h010, 32'h0, -1);

    request(1'b0, 1'b1, 1'b0, 32'h010, 32'h11223344, -1);
    request(1'b0, 1'b1, 1'b1, 32'h013, 32'hFFFFFFAA, -1);
    request(1'b1, 1'b0, 1'b0, 32'h010, 32'h0, -1);
    request(1'b1, 1'b0, 1'b1, 32'h012, 32'h0, -1);

    request(1'b1, 1'b0, 1'b0, 32'h006, 32'h0, -1);
    request(1'b1, 1'b1, 1'b0, 32'h010, 32'h99999999, -1);
    request(1'b0, 1'b1, 1'b0, 32'h00E, 32'h77777777, -1);
    request(1'b1, 1'b0, 1'b0, 32'h010, 32'h0, -1);

    request(1'b0, 1'b1, 1'b0, 32'h400, 32'h12345678, -1);
    request(1'b1, 1'b0, 1'b0, 32'h000, 32'h0, -1);

    request(1'b0, 1'b1, 1'b0, 32'h020, 32'hCAFEF00D, -1);
    request(1'b0, 1'b1, 1'b0, 32'h020, 32'h0BADBEEF, 3);
    request(1'b1, 1'b0, 1'b0, 32'h020, 32'h0, -1);

    request(1'b0, 1'b1, 1'b0, 32'h014, 32'h55667788, -1);
    b2b(0);
    b2b(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
